// File: rtl/noc_output_arbiter_if.sv
// Bundle between the input-port side of the router and one output-port arbiter.
// The arbiter uses the slave view; whoever drives requests and flits uses master.
interface noc_output_arbiter_if #(
  parameter int NUM_IN = 5,
  parameter int FLIT_W = 16,
  parameter int IDX_W  = 3
);
  logic [NUM_IN-1:0]        req_i;
  logic [NUM_IN-1:0]        tail_i;
  logic [NUM_IN*FLIT_W-1:0] flit_i;
  logic                     out_full_i;
  logic [NUM_IN-1:0]        grant_o;
  logic [FLIT_W-1:0]        flit_o;
  logic                     flit_valid_o;
  logic                     locked_o;
  logic [IDX_W-1:0]         owner_o;
  logic [15:0]              pkt_count_o;

  modport master (
    output req_i, tail_i, flit_i, out_full_i,
    input  grant_o, flit_o, flit_valid_o, locked_o, owner_o, pkt_count_o
  );

  modport slave (
    input  req_i, tail_i, flit_i, out_full_i,
    output grant_o, flit_o, flit_valid_o, locked_o, owner_o, pkt_count_o
  );
endinterface

// File: rtl/noc_output_arbiter.sv
// Wormhole round-robin switch arbiter for one router output port.
// The grant is combinational, so a winning flit moves in the cycle it wins;
// a packet whose head wins keeps the port until its tail flit has passed.
module noc_output_arbiter #(
  parameter int NUM_IN = 5,
  parameter int FLIT_W = 16,
  parameter int IDX_W  = 3
) (
  input logic                 clk,
  input logic                 rst,
  noc_output_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  state_t            state, state_next;
  logic [IDX_W-1:0]  ptr, ptr_next;
  logic [IDX_W-1:0]  owner, owner_next;
  logic [15:0]       pkt_count, pkt_count_next;

  logic [NUM_IN-1:0] hi_mask;
  logic [NUM_IN-1:0] req_hi;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;

  logic [NUM_IN-1:0] owner_onehot;
  logic              owner_req;

  logic              grant_any;
  logic [IDX_W-1:0]  grant_idx;
  logic [NUM_IN-1:0] grant;
  logic              grant_tail;
  logic [FLIT_W-1:0] flit_mux;

  // Round-robin successor of an input index, wrapping after the last input.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // Round-robin pick: prefer requesters at or above ptr, else wrap to the lowest one.
  always_comb begin
    hi_mask    = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      hi_mask[i] = (IDX_W'(i) >= ptr);
    end
    req_hi = bus.req_i & hi_mask;
    if (|req_hi) begin
      pick_found = 1'b1;
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (req_hi[i]) begin
          pick_idx = IDX_W'(i);
        end
      end
    end else if (|bus.req_i) begin
      pick_found = 1'b1;
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (bus.req_i[i]) begin
          pick_idx = IDX_W'(i);
        end
      end
    end
  end

  // Decode the owner index so its request can be tested without a variable bit-select.
  always_comb begin
    owner_onehot = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      owner_onehot[i] = (owner == IDX_W'(i));
    end
    owner_req = |(owner_onehot & bus.req_i);
  end

  // Output decode: who gets the port this cycle; reset and a full buffer block everything.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = owner;
    if (!rst && !bus.out_full_i) begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_any = 1'b1;
            grant_idx = pick_idx;
          end
        end
        LOCKED: begin
          if (owner_req) begin
            grant_any = 1'b1;
            grant_idx = owner;
          end
        end
        default: begin
          grant_any = 1'b0;
        end
      endcase
    end
  end

  // One-hot grant vector and the data mux that follows it.
  always_comb begin
    grant    = '0;
    flit_mux = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      grant[i] = grant_any && (grant_idx == IDX_W'(i));
      if (grant[i]) begin
        flit_mux = bus.flit_i[i*FLIT_W +: FLIT_W];
      end
    end
    grant_tail = |(grant & bus.tail_i);
  end

  // Next-state: a granted tail releases the port and advances the pointer past the winner.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    owner_next     = owner;
    pkt_count_next = pkt_count;
    if (grant_any) begin
      owner_next = grant_idx;
      if (grant_tail) begin
        state_next     = IDLE;
        ptr_next       = next_idx(grant_idx);
        pkt_count_next = pkt_count + 16'd1;
      end else begin
        state_next = LOCKED;
      end
    end
  end

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      pkt_count <= '0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      owner     <= owner_next;
      pkt_count <= pkt_count_next;
    end
  end

  assign bus.grant_o      = grant;
  assign bus.flit_o       = flit_mux;
  assign bus.flit_valid_o = |grant;
  assign bus.locked_o     = (state == LOCKED);
  assign bus.owner_o      = owner;
  assign bus.pkt_count_o  = pkt_count;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: a behavioural model predicts each cycle's grant,
// predicted flits go into a scoreboard queue and are popped as the DUT pushes them.
module tb_noc_output_arbiter;
  localparam int NUM_IN = 5;
  localparam int FLIT_W = 16;
  localparam int IDX_W  = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  noc_output_arbiter_if #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .IDX_W(IDX_W)) bus ();

  noc_output_arbiter #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .IDX_W(IDX_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit m_locked;
  int m_ptr;
  int m_owner;
  int m_cnt;
  bit e_valid;
  int e_idx;

  logic [FLIT_W-1:0] flits [NUM_IN];
  logic [FLIT_W-1:0] exp_q [$];

  // At most one grant per cycle.
  always @(negedge clk) begin
    assert ($onehot0(bus.grant_o))
      else $error("[TB] FAIL onehot grant=%b", bus.grant_o);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic void modelPredict(input logic r, input logic [NUM_IN-1:0] req, input logic full);
    e_valid = 1'b0;
    e_idx   = 0;
    if (r || full) return;
    if (m_locked) begin
      if (req[m_owner]) begin
        e_valid = 1'b1;
        e_idx   = m_owner;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        int c;
        c = (m_ptr + k) % NUM_IN;
        if (req[c]) begin
          e_valid = 1'b1;
          e_idx   = c;
          break;
        end
      end
    end
  endfunction

  function automatic void modelUpdate(input logic r, input logic [NUM_IN-1:0] tail);
    if (r) begin
      m_locked = 1'b0;
      m_ptr    = 0;
      m_owner  = 0;
      m_cnt    = 0;
    end else if (e_valid) begin
      m_owner = e_idx;
      if (tail[e_idx]) begin
        m_locked = 1'b0;
        m_ptr    = (e_idx + 1) % NUM_IN;
        m_cnt    = (m_cnt + 1) & 16'hFFFF;
      end else begin
        m_locked = 1'b1;
      end
    end
  endfunction

  // Drive one cycle of inputs, check the DUT against the model mid-cycle, then clock.
  task automatic applyStimulus(input logic r, input logic [NUM_IN-1:0] req,
                               input logic [NUM_IN-1:0] tail, input logic full,
                               output logic [NUM_IN-1:0] gnt_seen,
                               output logic [FLIT_W-1:0] flit_seen);
    logic [NUM_IN-1:0] exp_gnt;
    logic [FLIT_W-1:0] want;
    rst            = r;
    bus.req_i      = req;
    bus.tail_i     = tail;
    bus.out_full_i = full;
    for (int i = 0; i < NUM_IN; i++) bus.flit_i[i*FLIT_W +: FLIT_W] = flits[i];
    modelPredict(r, req, full);
    if (e_valid) exp_q.push_back(flits[e_idx]);
    @(negedge clk);
    exp_gnt = e_valid ? (NUM_IN'(1) << e_idx) : '0;
    checkOutput("grant", 32'(bus.grant_o), 32'(exp_gnt));
    checkOutput("valid", 32'(bus.flit_valid_o), 32'(e_valid));
    checkOutput("flit", 32'(bus.flit_o), e_valid ? 32'(flits[e_idx]) : 32'd0);
    checkOutput("locked", 32'(bus.locked_o), 32'(m_locked));
    checkOutput("owner", 32'(bus.owner_o), 32'(m_owner));
    checkOutput("count", 32'(bus.pkt_count_o), 32'(m_cnt));
    if (bus.flit_valid_o) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        want = exp_q.pop_front();
        checkOutput("sb_flit", 32'(bus.flit_o), 32'(want));
      end
    end
    gnt_seen  = bus.grant_o;
    flit_seen = bus.flit_o;
    @(posedge clk);
    modelUpdate(r, tail);
    #1;
  endtask

  logic [NUM_IN-1:0] g;
  logic [FLIT_W-1:0] f;
  int                seq;
  logic [NUM_IN-1:0] breq  [6] = '{5'b01000, 5'b10111, 5'b10111, 5'b11000, 5'b11000, 5'b11000};
  logic [NUM_IN-1:0] btail [6] = '{5'b00000, 5'b10111, 5'b10111, 5'b10000, 5'b11000, 5'b11000};
  logic [NUM_IN-1:0] bexp  [6] = '{5'b01000, 5'b00000, 5'b00000, 5'b01000, 5'b01000, 5'b10000};

  initial begin
    rst            = 1'b1;
    bus.req_i      = '0;
    bus.tail_i     = '0;
    bus.out_full_i = 1'b0;
    bus.flit_i     = '0;
    for (int i = 0; i < NUM_IN; i++) flits[i] = 16'hA000 + FLIT_W'(i);
    m_locked = 1'b0; m_ptr = 0; m_owner = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset blocks grants even with every input requesting
    applyStimulus(1'b1, 5'b11111, 5'b11111, 1'b0, g, f);
    checkOutput("rst_grant", 32'(g), 32'd0);
    checkOutput("rst_flit", 32'(f), 32'd0);

    // round-robin fairness and data mux
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 5'b11111, 5'b11111, 1'b0, g, f);
      checkOutput("rr_order", 32'(g), 32'(1 << (k % NUM_IN)));
      checkOutput("rr_flit", 32'(f), 32'(16'hA000 + k % NUM_IN));
    end
    checkOutput("rr_count", 32'(bus.pkt_count_o), 32'd10);

    // wormhole lock: input 2 four-flit packet, input 0 joins and must wait
    applyStimulus(1'b1, 5'b00000, 5'b00000, 1'b0, g, f);
    flits[0] = 16'hC000;
    for (int j = 0; j < 4; j++) begin
      flits[2] = 16'hB200 + FLIT_W'(j);
      applyStimulus(1'b0, (j == 0) ? 5'b00100 : 5'b00101,
                    (j == 3) ? 5'b00101 : 5'b00001, 1'b0, g, f);
      checkOutput("wh_grant", 32'(g), 32'b00100);
      checkOutput("wh_locked", 32'(bus.locked_o), 32'(j < 3));
      checkOutput("wh_count", 32'(bus.pkt_count_o), (j == 3) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 5'b00001, 5'b00001, 1'b0, g, f);
    checkOutput("wh_next", 32'(g), 32'b00001);
    checkOutput("wh_count2", 32'(bus.pkt_count_o), 32'd2);

    // backpressure mid-packet: input 1 five-flit packet, full for three cycles
    seq = 0;
    for (int c = 0; c < 12 && seq < 5; c++) begin
      logic full;
      full     = (c >= 2 && c <= 4);
      flits[1] = 16'hB100 + FLIT_W'(seq);
      applyStimulus(1'b0, 5'b10010, (seq == 4) ? 5'b10010 : 5'b10000, full, g, f);
      if (full) begin
        checkOutput("bp_grant", 32'(g), 32'd0);
        checkOutput("bp_locked", 32'(bus.locked_o), 32'd1);
      end
      if (g[1]) seq++;
    end
    checkOutput("bp_done", 32'(seq), 32'd5);

    // owner bubble: input 3 drops its request for two cycles while others ask
    seq = 0;
    for (int c = 0; c < 6; c++) begin
      flits[3] = 16'hB300 + FLIT_W'(seq);
      applyStimulus(1'b0, breq[c], btail[c], 1'b0, g, f);
      checkOutput("bub_grant", 32'(g), 32'(bexp[c]));
      if (c == 1 || c == 2) checkOutput("bub_locked", 32'(bus.locked_o), 32'd1);
      if (g[3]) seq++;
    end

    // reset in the middle of a four-flit packet from input 2
    flits[2] = 16'hB200;
    applyStimulus(1'b0, 5'b00100, 5'b00000, 1'b0, g, f);
    checkOutput("rm_first", 32'(g), 32'b00100);
    flits[2] = 16'hB201;
    applyStimulus(1'b1, 5'b00100, 5'b00000, 1'b0, g, f);
    checkOutput("rm_grant", 32'(g), 32'd0);
    checkOutput("rm_locked", 32'(bus.locked_o), 32'd0);
    checkOutput("rm_count", 32'(bus.pkt_count_o), 32'd0);
    checkOutput("rm_owner", 32'(bus.owner_o), 32'd0);
    applyStimulus(1'b0, 5'b11111, 5'b11111, 1'b0, g, f);
    checkOutput("rm_ptr0", 32'(g), 32'b00001);
    applyStimulus(1'b0, 5'b01000, 5'b01000, 1'b0, g, f);
    checkOutput("rm_in3", 32'(g), 32'b01000);

    checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Per-output-port switch arbiter for the NoC router; one instance sits in front of each output port.
- Shares the output port buffer among all input ports requesting that direction.
- Wormhole, round-robin: a packet that wins keeps the port until its tail flit passes.
- Drives the output port's push enable and data, and backs off when the port buffer reports full.

Parameters:
- NUM_IN, 5, number of requesting input ports (N, S, E, W, local).
- FLIT_W, 16, flit width in bits.
- IDX_W, 3, width of an input index; must satisfy 2**IDX_W >= NUM_IN.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- req_i  input  NUM_IN  bit i high: input i has a flit at its head routed to this output.
- tail_i  input  NUM_IN  bit i high: input i's head flit is the tail of its packet.
- flit_i  input  NUM_IN*FLIT_W  head flits; input i occupies bits [i*FLIT_W +: FLIT_W].
- out_full_i  input  1  full flag from the output port buffer.
- grant_o  output  NUM_IN  one-hot; input i pops its head flit this cycle.
- flit_o  output  FLIT_W  flit_i slice of the granted input; 0 when no grant.
- flit_valid_o  output  1  push enable to the output port; equals |grant_o.
- locked_o  output  1  high while a multi-flit packet owns the port.
- owner_o  output  IDX_W  index of the current owner, or of the last granted input.
- pkt_count_o  output  16  tail flits forwarded since reset; wraps modulo 2^16.

Behaviour:
- Grant logic is combinational from the current state and inputs. The same cycle's grant moves the flit: zero-cycle arbitration latency.
- State, ptr, owner_o and pkt_count_o update on the rising clk edge.

Reset:
- Any cycle with rst high forces grant_o=0, flit_valid_o=0 and flit_o=0 combinationally.
- At the edge: state=IDLE, ptr=0, owner_o=0, locked_o=0, pkt_count_o=0.
- Reset mid-packet drops the lock. The partial packet is abandoned; the arbiter does not recover it.

States:
- IDLE:
  - If out_full_i=1 or req_i=0: no grant, state unchanged.
  - Otherwise grant the first set req_i bit scanning ptr, ptr+1, ... NUM_IN-1, 0, ... ptr-1. Call it g; owner_o<=g.
  - If tail_i[g]=1 (single-flit packet): stay IDLE, ptr<=(g+1) mod NUM_IN, pkt_count_o increments.
  - If tail_i[g]=0: go to LOCKED, ptr unchanged.
- LOCKED (locked_o=1):
  - Only owner_o may be granted; req_i from other inputs is ignored.
  - Grant owner_o when req_i[owner_o]=1 and out_full_i=0. Otherwise no grant that cycle (a bubble), and the state holds.
  - A granted flit with tail_i[owner_o]=1: go to IDLE, ptr<=(owner_o+1) mod NUM_IN, pkt_count_o increments.
  - The next packet can be granted in the cycle immediately after the tail. No dead cycle is inserted.

Boundaries:
- out_full_i high at any time: never grant, and nothing is pushed into a full buffer.
- Grant is dropped in the cycle that full rises. The buffer's full flag already reflects a push from the prior cycle, so no extra margin is needed.
- ptr wraps from NUM_IN-1 to 0.
- pkt_count_o wraps from 16'hFFFF to 0.
- tail_i bits without the matching req_i bit are ignored.
- At most one grant_o bit is high in any cycle. The bench checks this with an assertion.

Test Plan:
- Round-robin fairness: from reset, req_i=5'b11111 with all tail_i=1 and out_full_i=0 for 10 cycles. Grant order is 0,1,2,3,4,0,1,2,3,4; pkt_count_o=10.
- Wormhole lock: input 2 sends a 4-flit packet (tail on the 4th) while input 0 requests continuously.
  - Grants go to 2 for 4 cycles with locked_o=1.
  - In cycle 5, input 0 is granted, since ptr=3 and the scan wraps to 0.
  - pkt_count_o goes 0→1→2.
- Backpressure: out_full_i=1 for 3 cycles mid-packet. grant_o=0, flit_valid_o=0, locked_o stays 1. The packet resumes with no flit lost or duplicated, checked with a scoreboard.
- Owner bubble: in LOCKED, req_i[owner] is low for 2 cycles while other inputs request. No grant is issued to any input, and the lock is held.
- Reset mid-packet: rst asserted during flit 2 of 4.
  - Next cycle: locked_o=0, ptr=0, pkt_count_o=0.
  - A subsequent request from input 3 is granted immediately.
- Data mux: flit_i slices set to 16'hA000+i. Each grant yields flit_o=16'hA000+g. flit_o=0 whenever grant_o=0.
